// File: rtl/apb_evt_pkg.sv
// Shared types and constants for the APB event arbiter.
package apb_evt_pkg;

   // Bus-side protocol state of the single APB write master.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // The block only ever issues writes.
   localparam logic APB_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after last_grant wins.
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_grant,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0] cand;

   // Walk indices last_grant+1 .. last_grant+N (mod N); the first set request wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= N; i++) begin
         cand = IDX_W'((int'(last_grant) + i) % N);
         if (!gnt_valid && req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/apb_event_arbiter.sv
// Per-source saturating event counters drained by round-robin APB writes.
module apb_event_arbiter
   import apb_evt_pkg::*;
#(
   parameter int          NUM_SRC     = 4,
   parameter int          CNT_W       = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
   parameter logic [31:0] ADDR_STRIDE = 32'h0000_0100
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] event_i,
   output logic               apb_psel_o,
   output logic               apb_penable_o,
   output logic [31:0]        apb_paddr_o,
   output logic               apb_pwrite_o,
   output logic [31:0]        apb_pwdata_o,
   input  logic               apb_pready_i,
   output logic [NUM_SRC-1:0] overflow_o,
   output logic               busy_o
);

   localparam int              IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             state;
   state_t             state_next;
   logic               grant;
   logic               gnt_valid;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   last_grant;
   logic [NUM_SRC-1:0] pend;
   logic [CNT_W-1:0]   cnt [NUM_SRC];
   logic [31:0]        paddr;
   logic [31:0]        pwdata;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [CNT_W-1:0] count;
         logic             ovf;
         logic             snap;
         logic             sat;

         assign snap      = grant && (gnt_idx == IDX_W'(gi));
         assign sat       = (count == CNT_MAX);
         assign cnt[gi]   = count;
         assign pend[gi]  = (count != '0);
         assign overflow_o[gi] = ovf;

         // Count events; a snapshot restarts the count with this cycle's event so
         // nothing is lost. Saturated events set the sticky overflow flag, which a
         // snapshot clears (on the snapshot edge the event lands in the new count).
         always_ff @(posedge clk) begin
            if (!reset) begin
               count <= '0;
               ovf   <= 1'b0;
            end else begin
               if (snap) begin
                  count <= CNT_W'(event_i[gi]);
               end else if (event_i[gi] && !sat) begin
                  count <= count + 1'b1;
               end
               if (event_i[gi] && sat && !snap) begin
                  ovf <= 1'b1;
               end else if (snap) begin
                  ovf <= 1'b0;
               end
            end
         end
      end
   endgenerate

   rr_arbiter #(
      .N (NUM_SRC)
   ) u_rr (
      .req        (pend),
      .last_grant (last_grant),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, grant strobe and APB control outputs.
   always_comb begin
      state_next    = state;
      grant         = 1'b0;
      apb_psel_o    = 1'b0;
      apb_penable_o = 1'b0;
      apb_pwrite_o  = 1'b0;
      busy_o        = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_valid) begin
               grant      = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            apb_psel_o   = 1'b1;
            apb_pwrite_o = APB_WRITE;
            busy_o       = 1'b1;
            state_next   = ACCESS;
         end
         ACCESS: begin
            apb_psel_o    = 1'b1;
            apb_penable_o = 1'b1;
            apb_pwrite_o  = APB_WRITE;
            busy_o        = 1'b1;
            if (apb_pready_i) begin
               if (gnt_valid) begin
                  grant      = 1'b1;
                  state_next = SETUP;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Snapshot address/data on the grant edge; held until the next grant.
   always_ff @(posedge clk) begin
      if (!reset) begin
         paddr      <= '0;
         pwdata     <= '0;
         last_grant <= IDX_W'(NUM_SRC - 1);
      end else if (grant) begin
         paddr      <= BASE_ADDR + (32'(gnt_idx) * ADDR_STRIDE);
         pwdata     <= 32'(cnt[gnt_idx]);
         last_grant <= gnt_idx;
      end
   end

   assign apb_paddr_o  = paddr;
   assign apb_pwdata_o = pwdata;

endmodule

// File: tb/tb_apb_event_arbiter.sv
// Directed bench with per-DUT scoreboards of expected APB writes.
module tb_apb_event_arbiter;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  ev;
   logic        pready;
   logic        psel, penable, pwrite, busy;
   logic [31:0] paddr, pwdata;
   logic [3:0]  ovf;

   logic [3:0]  ev2;
   logic        pready2;
   logic        psel2, penable2, pwrite2, busy2;
   logic [31:0] paddr2, pwdata2;
   logic [3:0]  ovf2;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   apb_event_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .event_i       (ev),
      .apb_psel_o    (psel),
      .apb_penable_o (penable),
      .apb_paddr_o   (paddr),
      .apb_pwrite_o  (pwrite),
      .apb_pwdata_o  (pwdata),
      .apb_pready_i  (pready),
      .overflow_o    (ovf),
      .busy_o        (busy)
   );

   apb_event_arbiter #(.CNT_W(4)) dut2 (
      .clk           (clk),
      .reset         (reset),
      .event_i       (ev2),
      .apb_psel_o    (psel2),
      .apb_penable_o (penable2),
      .apb_paddr_o   (paddr2),
      .apb_pwrite_o  (pwrite2),
      .apb_pwdata_o  (pwdata2),
      .apb_pready_i  (pready2),
      .overflow_o    (ovf2),
      .busy_o        (busy2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      q1.push_back(e);
   endtask

   task automatic push2(input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      q2.push_back(e);
   endtask

   task automatic wait_idle1();
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      chk("dut1_idle_timeout", 32'(busy), 32'd0);
      chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
   endtask

   task automatic wait_idle2();
      int n = 0;
      while (busy2 !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      chk("dut2_idle_timeout", 32'(busy2), 32'd0);
      chk("dut2_queue_drained", 32'(q2.size()), 32'd0);
   endtask

   // Scoreboard for dut: a write completes on the edge after psel&penable&pready.
   always @(negedge clk) begin
      if (reset === 1'b1 && psel === 1'b1 && penable === 1'b1 && pready === 1'b1) begin
         if (q1.size() == 0) begin
            chk("dut1_unexpected_write", 32'(q1.size()), 32'd1);
         end else begin
            e1 = q1.pop_front();
            $display("dut1 write addr=0x%08h data=%0d (exp 0x%08h/%0d)", paddr, pwdata, e1.addr, e1.data);
            chk("dut1_paddr", paddr, e1.addr);
            chk("dut1_pwdata", pwdata, e1.data);
            chk("dut1_pwrite", 32'(pwrite), 32'd1);
         end
      end
   end

   // Scoreboard for dut2 (4-bit counters).
   always @(negedge clk) begin
      if (reset === 1'b1 && psel2 === 1'b1 && penable2 === 1'b1 && pready2 === 1'b1) begin
         if (q2.size() == 0) begin
            chk("dut2_unexpected_write", 32'(q2.size()), 32'd1);
         end else begin
            e2 = q2.pop_front();
            $display("dut2 write addr=0x%08h data=%0d (exp 0x%08h/%0d)", paddr2, pwdata2, e2.addr, e2.data);
            chk("dut2_paddr", paddr2, e2.addr);
            chk("dut2_pwdata", pwdata2, e2.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b0;
      ev      = '0;
      pready  = 1'b1;
      ev2     = '0;
      pready2 = 1'b1;
      repeat (3) tick();

      // Reset state
      chk("rst_psel", 32'(psel), 32'd0);
      chk("rst_penable", 32'(penable), 32'd0);
      chk("rst_pwrite", 32'(pwrite), 32'd0);
      chk("rst_paddr", paddr, 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);
      chk("rst_overflow", 32'(ovf), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      repeat (2) tick();

      // Single pulse on src0
      push1(32'h4000_0000, 32'd1);
      ev = 4'b0001;
      tick();
      chk("t1_psel_after_sample", 32'(psel), 32'd0);
      ev = 4'b0000;
      tick();
      chk("t1_psel_setup", 32'(psel), 32'd1);
      chk("t1_penable_setup", 32'(penable), 32'd0);
      chk("t1_paddr", paddr, 32'h4000_0000);
      chk("t1_pwdata", pwdata, 32'd1);
      chk("t1_pwrite", 32'(pwrite), 32'd1);
      tick();
      chk("t1_penable_access", 32'(penable), 32'd1);
      tick();
      chk("t1_psel_idle", 32'(psel), 32'd0);
      chk("t1_busy_idle", 32'(busy), 32'd0);
      wait_idle1();

      // src1 accumulates 5, src3 accumulates 2 behind a stalled src0 write
      push1(32'h4000_0000, 32'd1);
      push1(32'h4000_0100, 32'd5);
      push1(32'h4000_0300, 32'd2);
      pready = 1'b0;
      ev = 4'b0001;
      tick();
      ev = 4'b1010;
      repeat (2) tick();
      ev = 4'b0010;
      repeat (3) tick();
      ev = 4'b0000;
      pready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_psel_back_to_back", 32'(psel), 32'd1);
      end
      tick();
      chk("t2_psel_end", 32'(psel), 32'd0);
      wait_idle1();

      // All sources pulse for 16 cycles: order 0,1,2,3,... with accumulated counts
      begin
         logic [31:0] cnts [12];
         cnts = '{1, 3, 5, 7, 8, 8, 8, 8, 7, 5, 3, 1};
         for (int i = 0; i < 12; i++) begin
            push1(32'h4000_0000 + 32'(i % 4) * 32'h100, cnts[i]);
         end
      end
      ev = 4'b1111;
      repeat (16) tick();
      ev = 4'b0000;
      wait_idle1();

      // Stall ACCESS for 5 cycles while src0 keeps pulsing
      push1(32'h4000_0000, 32'd1);
      push1(32'h4000_0000, 32'd6);
      pready = 1'b0;
      ev = 4'b0001;
      tick();
      tick();
      chk("t4_setup_psel", 32'(psel), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_penable_held", 32'(penable), 32'd1);
         chk("t4_paddr_stable", paddr, 32'h4000_0000);
         chk("t4_pwdata_stable", pwdata, 32'd1);
      end
      ev = 4'b0000;
      pready = 1'b1;
      wait_idle1();

      // CNT_W=4: 17 events on src2 behind a stalled src0 write
      push2(32'h4000_0000, 32'd1);
      push2(32'h4000_0200, 32'd15);
      pready2 = 1'b0;
      ev2 = 4'b0001;
      tick();
      ev2 = 4'b0100;
      for (int i = 1; i <= 17; i++) begin
         tick();
         chk("t5_overflow_pre_grant", 32'(ovf2[2]), (i >= 16) ? 32'd1 : 32'd0);
      end
      ev2 = 4'b0000;
      pready2 = 1'b1;
      tick();
      chk("t5_overflow_cleared", 32'(ovf2[2]), 32'd0);
      chk("t5_snapshot_pwdata", pwdata2, 32'd15);
      chk("t5_snapshot_paddr", paddr2, 32'h4000_0200);
      wait_idle2();

      // Reset during ACCESS with src3 pending
      pready = 1'b0;
      ev = 4'b0010;
      tick();
      ev = 4'b1000;
      tick();
      tick();
      chk("t6_in_access", 32'(penable), 32'd1);
      reset = 1'b0;
      ev = 4'b0000;
      tick();
      chk("t6_psel_after_reset", 32'(psel), 32'd0);
      chk("t6_penable_after_reset", 32'(penable), 32'd0);
      chk("t6_busy_after_reset", 32'(busy), 32'd0);
      chk("t6_pwdata_after_reset", pwdata, 32'd0);
      reset = 1'b1;
      pready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_counts_discarded", 32'(psel), 32'd0);
      end
      push1(32'h4000_0000, 32'd1);
      push1(32'h4000_0300, 32'd1);
      ev = 4'b1001;
      tick();
      ev = 4'b0000;
      tick();
      chk("t6_tie_src0_first", paddr, 32'h4000_0000);
      wait_idle1();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
